// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - AXI3 responder over a word-addressed SRAM model
// Read and write channels run independent FSMs; out-of-range beats answer SLVERR.
module axi_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1C00_0000,
  parameter int          DEPTH_WORDS = 65536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_axi_ar_valid,
  output logic        io_axi_ar_ready,
  input  logic [3:0]  io_axi_ar_bits_id,
  input  logic [31:0] io_axi_ar_bits_addr,
  input  logic [7:0]  io_axi_ar_bits_len,
  input  logic [2:0]  io_axi_ar_bits_size,
  input  logic [1:0]  io_axi_ar_bits_burst,
  output logic        io_axi_r_valid,
  input  logic        io_axi_r_ready,
  output logic [3:0]  io_axi_r_bits_id,
  output logic [31:0] io_axi_r_bits_data,
  output logic [1:0]  io_axi_r_bits_resp,
  output logic        io_axi_r_bits_last,
  input  logic        io_axi_aw_valid,
  output logic        io_axi_aw_ready,
  input  logic [3:0]  io_axi_aw_bits_id,
  input  logic [31:0] io_axi_aw_bits_addr,
  input  logic [7:0]  io_axi_aw_bits_len,
  input  logic [2:0]  io_axi_aw_bits_size,
  input  logic [1:0]  io_axi_aw_bits_burst,
  input  logic        io_axi_w_valid,
  output logic        io_axi_w_ready,
  input  logic [31:0] io_axi_w_bits_data,
  input  logic [3:0]  io_axi_w_bits_strb,
  input  logic        io_axi_w_bits_last,
  output logic        io_axi_b_valid,
  input  logic        io_axi_b_ready,
  output logic [3:0]  io_axi_b_bits_id,
  output logic [1:0]  io_axi_b_bits_resp
);
  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] step, mask;
    step = 32'd1 << size;
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | ((a + step) & mask);
      default: next_addr = a + step;
    endcase
  endfunction

  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  rstate_t     rstate;
  wstate_t     wstate;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] r_addr;
  logic [7:0]  r_len, r_beat;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [8:0]  w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_err;

  logic          ar_fire, r_fire, aw_fire, w_fire, b_fire, w_hit, w_beat_bad;
  logic [AW-1:0] w_idx, ld_idx;
  logic [31:0]   r_next, ld_addr, ld_data;

  assign ar_fire = io_axi_ar_valid & io_axi_ar_ready;
  assign r_fire  = io_axi_r_valid & io_axi_r_ready;
  assign aw_fire = io_axi_aw_valid & io_axi_aw_ready;
  assign w_fire  = io_axi_w_valid & io_axi_w_ready;
  assign b_fire  = io_axi_b_valid & io_axi_b_ready;
  assign w_hit   = w_fire & in_range(w_addr);
  assign w_idx   = word_idx(w_addr);

  assign w_beat_bad = !in_range(w_addr) | (w_cnt > {1'b0, w_len}) |
                      (io_axi_w_bits_last & (w_cnt != {1'b0, w_len}));

  // Read data is captured when a beat is first offered; a same-edge write is forwarded
  // so the captured word matches what the SRAM holds from the next cycle on.
  assign r_next  = next_addr(r_addr, r_size, r_len, r_burst);
  assign ld_addr = (rstate == R_IDLE) ? io_axi_ar_bits_addr : r_next;
  assign ld_idx  = word_idx(ld_addr);

  always_comb begin
    ld_data = 32'd0;
    if (in_range(ld_addr)) begin
      ld_data = mem[ld_idx];
      if (w_hit && (w_idx == ld_idx)) begin
        for (int i = 0; i < 4; i++) begin
          if (io_axi_w_bits_strb[i]) ld_data[8*i +: 8] = io_axi_w_bits_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (io_axi_w_bits_strb[i]) mem[w_idx][8*i +: 8] <= io_axi_w_bits_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rstate             <= R_IDLE;
      io_axi_ar_ready    <= 1'b1;
      io_axi_r_valid     <= 1'b0;
      io_axi_r_bits_id   <= 4'd0;
      io_axi_r_bits_data <= 32'd0;
      io_axi_r_bits_resp <= 2'b00;
      io_axi_r_bits_last <= 1'b0;
      r_addr             <= 32'd0;
      r_len              <= 8'd0;
      r_beat             <= 8'd0;
      r_size             <= 3'd0;
      r_burst            <= 2'b00;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_fire) begin
            rstate             <= R_DATA;
            io_axi_ar_ready    <= 1'b0;
            io_axi_r_valid     <= 1'b1;
            io_axi_r_bits_id   <= io_axi_ar_bits_id;
            io_axi_r_bits_data <= ld_data;
            io_axi_r_bits_resp <= in_range(io_axi_ar_bits_addr) ? 2'b00 : 2'b10;
            io_axi_r_bits_last <= (io_axi_ar_bits_len == 8'd0);
            r_addr             <= io_axi_ar_bits_addr;
            r_len              <= io_axi_ar_bits_len;
            r_size             <= io_axi_ar_bits_size;
            r_burst            <= io_axi_ar_bits_burst;
            r_beat             <= 8'd0;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (io_axi_r_bits_last) begin
              rstate             <= R_IDLE;
              io_axi_ar_ready    <= 1'b1;
              io_axi_r_valid     <= 1'b0;
              io_axi_r_bits_last <= 1'b0;
            end else begin
              r_addr             <= r_next;
              r_beat             <= r_beat + 8'd1;
              io_axi_r_bits_last <= ((r_beat + 8'd1) == r_len);
              io_axi_r_bits_data <= ld_data;
              io_axi_r_bits_resp <= in_range(r_next) ? 2'b00 : 2'b10;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wstate             <= W_IDLE;
      io_axi_aw_ready    <= 1'b1;
      io_axi_w_ready     <= 1'b0;
      io_axi_b_valid     <= 1'b0;
      io_axi_b_bits_id   <= 4'd0;
      io_axi_b_bits_resp <= 2'b00;
      w_addr             <= 32'd0;
      w_len              <= 8'd0;
      w_cnt              <= 9'd0;
      w_size             <= 3'd0;
      w_burst            <= 2'b00;
      w_err              <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_fire) begin
            wstate           <= W_DATA;
            io_axi_aw_ready  <= 1'b0;
            io_axi_w_ready   <= 1'b1;
            io_axi_b_bits_id <= io_axi_aw_bits_id;
            w_addr           <= io_axi_aw_bits_addr;
            w_len            <= io_axi_aw_bits_len;
            w_size           <= io_axi_aw_bits_size;
            w_burst          <= io_axi_aw_bits_burst;
            w_cnt            <= 9'd0;
            w_err            <= 1'b0;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
            // Counter saturates one past len; overlong bursts are already flagged.
            if (w_cnt <= {1'b0, w_len}) w_cnt <= w_cnt + 9'd1;
            if (w_beat_bad) w_err <= 1'b1;
            if (io_axi_w_bits_last) begin
              wstate             <= W_RESP;
              io_axi_w_ready     <= 1'b0;
              io_axi_b_valid     <= 1'b1;
              io_axi_b_bits_resp <= (w_err | w_beat_bad) ? 2'b10 : 2'b00;
            end
          end
        end
        W_RESP: begin
          if (b_fire) begin
            wstate          <= W_IDLE;
            io_axi_b_valid  <= 1'b0;
            io_axi_aw_ready <= 1'b1;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_responder.sv
// tb/tb_axi_sram_responder.sv - randomized bench for axi_sram_responder against a memory model
module tb_axi_sram_responder;
  localparam logic [31:0] BASE = 32'h1C00_0000;
  localparam logic [31:0] TOP  = 32'h1C04_0000;
  localparam int          MW   = 256;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        io_axi_ar_valid, io_axi_ar_ready;
  logic [3:0]  io_axi_ar_bits_id;
  logic [31:0] io_axi_ar_bits_addr;
  logic [7:0]  io_axi_ar_bits_len;
  logic [2:0]  io_axi_ar_bits_size;
  logic [1:0]  io_axi_ar_bits_burst;
  logic        io_axi_r_valid, io_axi_r_ready;
  logic [3:0]  io_axi_r_bits_id;
  logic [31:0] io_axi_r_bits_data;
  logic [1:0]  io_axi_r_bits_resp;
  logic        io_axi_r_bits_last;
  logic        io_axi_aw_valid, io_axi_aw_ready;
  logic [3:0]  io_axi_aw_bits_id;
  logic [31:0] io_axi_aw_bits_addr;
  logic [7:0]  io_axi_aw_bits_len;
  logic [2:0]  io_axi_aw_bits_size;
  logic [1:0]  io_axi_aw_bits_burst;
  logic        io_axi_w_valid, io_axi_w_ready;
  logic [31:0] io_axi_w_bits_data;
  logic [3:0]  io_axi_w_bits_strb;
  logic        io_axi_w_bits_last;
  logic        io_axi_b_valid, io_axi_b_ready;
  logic [3:0]  io_axi_b_bits_id;
  logic [1:0]  io_axi_b_bits_resp;

  axi_sram_responder dut (
    .clock(clock), .reset(reset),
    .io_axi_ar_valid(io_axi_ar_valid), .io_axi_ar_ready(io_axi_ar_ready),
    .io_axi_ar_bits_id(io_axi_ar_bits_id), .io_axi_ar_bits_addr(io_axi_ar_bits_addr),
    .io_axi_ar_bits_len(io_axi_ar_bits_len), .io_axi_ar_bits_size(io_axi_ar_bits_size),
    .io_axi_ar_bits_burst(io_axi_ar_bits_burst),
    .io_axi_r_valid(io_axi_r_valid), .io_axi_r_ready(io_axi_r_ready),
    .io_axi_r_bits_id(io_axi_r_bits_id), .io_axi_r_bits_data(io_axi_r_bits_data),
    .io_axi_r_bits_resp(io_axi_r_bits_resp), .io_axi_r_bits_last(io_axi_r_bits_last),
    .io_axi_aw_valid(io_axi_aw_valid), .io_axi_aw_ready(io_axi_aw_ready),
    .io_axi_aw_bits_id(io_axi_aw_bits_id), .io_axi_aw_bits_addr(io_axi_aw_bits_addr),
    .io_axi_aw_bits_len(io_axi_aw_bits_len), .io_axi_aw_bits_size(io_axi_aw_bits_size),
    .io_axi_aw_bits_burst(io_axi_aw_bits_burst),
    .io_axi_w_valid(io_axi_w_valid), .io_axi_w_ready(io_axi_w_ready),
    .io_axi_w_bits_data(io_axi_w_bits_data), .io_axi_w_bits_strb(io_axi_w_bits_strb),
    .io_axi_w_bits_last(io_axi_w_bits_last),
    .io_axi_b_valid(io_axi_b_valid), .io_axi_b_ready(io_axi_b_ready),
    .io_axi_b_bits_id(io_axi_b_bits_id), .io_axi_b_bits_resp(io_axi_b_bits_resp)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model [MW];
  logic [31:0] dq[$];
  logic [3:0]  sq[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit m_in_range(input logic [31:0] a);
    return (a >= BASE) && (a < TOP);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'(((a - BASE) / 32'd4) % 32'(MW));
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] a, input logic [2:0] size,
                                         input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] step, win, lo;
    step = 32'd1 << size;
    if (burst == 2'b00) return a;
    if (burst == 2'b10) begin
      win = (32'(len) + 32'd1) * step;
      lo  = a - (a % win);
      return lo + ((a + step - lo) % win);
    end
    return a + step;
  endfunction

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit bp);
    logic [31:0] a, ed;
    logic [1:0]  er;
    int          beat, cyc;
    bit          have, fire;
    a = addr; beat = 0; cyc = 0; have = 0;
    check_eq("ar_ready_idle", 32'(io_axi_ar_ready), 32'd1);
    io_axi_ar_valid = 1'b1; io_axi_ar_bits_id = id; io_axi_ar_bits_addr = addr;
    io_axi_ar_bits_len = len; io_axi_ar_bits_size = size; io_axi_ar_bits_burst = burst;
    @(negedge clock);
    io_axi_ar_valid = 1'b0;
    check_eq("r_first_latency", 32'(io_axi_r_valid), 32'd1);
    while (beat <= int'(len) && cyc < 400) begin
      io_axi_r_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      check_eq("r_valid", 32'(io_axi_r_valid), 32'd1);
      if (!have) begin
        have = 1;
        er   = m_in_range(a) ? 2'b00 : 2'b10;
        ed   = m_in_range(a) ? model[m_idx(a)] : 32'd0;
      end
      check_eq("r_data", io_axi_r_bits_data, ed);
      check_eq("r_resp", 32'(io_axi_r_bits_resp), 32'(er));
      check_eq("r_last", 32'(io_axi_r_bits_last), 32'(beat == int'(len)));
      check_eq("r_id", 32'(io_axi_r_bits_id), 32'(id));
      fire = io_axi_r_valid && io_axi_r_ready;
      @(negedge clock);
      cyc++;
      if (fire) begin
        beat++;
        have = 0;
        a = m_next(a, size, len, burst);
      end
    end
    io_axi_r_ready = 1'b0;
    if (beat <= int'(len)) check_eq("r_beats_timeout", 32'(beat), 32'(len) + 32'd1);
    check_eq("r_valid_after_last", 32'(io_axi_r_valid), 32'd0);
    check_eq("ar_ready_after_last", 32'(io_axi_ar_ready), 32'd1);
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                             input bit bp, input logic [31:0] dat[$], input logic [3:0] stb[$]);
    logic [31:0] a;
    logic [1:0]  eresp;
    int          beat, cyc, k;
    bit          bad, fire;
    a = addr; beat = 0; cyc = 0; bad = 0;
    check_eq("aw_ready_idle", 32'(io_axi_aw_ready), 32'd1);
    io_axi_aw_valid = 1'b1; io_axi_aw_bits_id = id; io_axi_aw_bits_addr = addr;
    io_axi_aw_bits_len = len; io_axi_aw_bits_size = size; io_axi_aw_bits_burst = burst;
    io_axi_w_valid = 1'b1; io_axi_w_bits_data = dat[0]; io_axi_w_bits_strb = stb[0];
    io_axi_w_bits_last = (nbeats == 1);
    check_eq("w_ready_before_aw", 32'(io_axi_w_ready), 32'd0);
    @(negedge clock);
    io_axi_aw_valid = 1'b0;
    check_eq("w_ready_after_aw", 32'(io_axi_w_ready), 32'd1);
    while (beat < nbeats && cyc < 400) begin
      io_axi_w_valid     = !(bp && $urandom_range(0, 3) == 0);
      io_axi_w_bits_data = dat[beat];
      io_axi_w_bits_strb = stb[beat];
      io_axi_w_bits_last = (beat == nbeats - 1);
      fire = io_axi_w_valid && io_axi_w_ready;
      @(posedge clock);
      if (fire) begin
        if (m_in_range(a)) begin
          k = m_idx(a);
          for (int i = 0; i < 4; i++) if (stb[beat][i]) model[k][8*i +: 8] = dat[beat][8*i +: 8];
        end else begin
          bad = 1;
        end
        a = m_next(a, size, len, burst);
        beat++;
      end
      @(negedge clock);
      cyc++;
    end
    io_axi_w_valid = 1'b0;
    io_axi_w_bits_last = 1'b0;
    if (beat < nbeats) check_eq("w_beats_timeout", 32'(beat), 32'(nbeats));
    check_eq("b_latency", 32'(io_axi_b_valid), 32'd1);
    eresp = (bad || nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
    cyc = 0; fire = 0;
    while (!fire && cyc < 100) begin
      io_axi_b_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      check_eq("b_valid", 32'(io_axi_b_valid), 32'd1);
      check_eq("b_id", 32'(io_axi_b_bits_id), 32'(id));
      check_eq("b_resp", 32'(io_axi_b_bits_resp), 32'(eresp));
      fire = io_axi_b_valid && io_axi_b_ready;
      @(negedge clock);
      cyc++;
    end
    io_axi_b_ready = 1'b0;
    if (!fire) check_eq("b_handshake", 32'(fire), 32'd1);
    check_eq("b_valid_after", 32'(io_axi_b_valid), 32'd0);
    check_eq("aw_ready_after", 32'(io_axi_aw_ready), 32'd1);
  endtask

  task automatic fill_random(input int n, input bit rnd_strb);
    dq = {}; sq = {};
    for (int j = 0; j < n; j++) begin
      dq.push_back($urandom);
      sq.push_back(rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    io_axi_ar_valid = 0; io_axi_ar_bits_id = 0; io_axi_ar_bits_addr = 0; io_axi_ar_bits_len = 0;
    io_axi_ar_bits_size = 0; io_axi_ar_bits_burst = 0; io_axi_r_ready = 0;
    io_axi_aw_valid = 0; io_axi_aw_bits_id = 0; io_axi_aw_bits_addr = 0; io_axi_aw_bits_len = 0;
    io_axi_aw_bits_size = 0; io_axi_aw_bits_burst = 0;
    io_axi_w_valid = 0; io_axi_w_bits_data = 0; io_axi_w_bits_strb = 0; io_axi_w_bits_last = 0;
    io_axi_b_ready = 0;
    for (int i = 0; i < MW; i++) model[i] = 32'd0;

    repeat (3) @(negedge clock);
    check_eq("rst_ar_ready", 32'(io_axi_ar_ready), 32'd1);
    check_eq("rst_aw_ready", 32'(io_axi_aw_ready), 32'd1);
    check_eq("rst_r_valid", 32'(io_axi_r_valid), 32'd0);
    check_eq("rst_w_ready", 32'(io_axi_w_ready), 32'd0);
    check_eq("rst_b_valid", 32'(io_axi_b_valid), 32'd0);
    check_eq("rst_r_last", 32'(io_axi_r_bits_last), 32'd0);
    check_eq("rst_r_resp", 32'(io_axi_r_bits_resp), 32'd0);
    check_eq("rst_b_resp", 32'(io_axi_b_bits_resp), 32'd0);
    check_eq("rst_r_id", 32'(io_axi_r_bits_id), 32'd0);
    check_eq("rst_b_id", 32'(io_axi_b_bits_id), 32'd0);
    check_eq("rst_r_data", io_axi_r_bits_data, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Front-door preload of the first 64 words so every word read later is defined.
    for (int k = 0; k < 4; k++) begin
      fill_random(16, 1'b0);
      write_burst(4'(k), BASE + 32'(k * 64), 8'd15, 3'd2, 2'b01, 16, 1'b0, dq, sq);
    end

    dq = {32'h11, 32'h22, 32'h33, 32'h44}; sq = {4'hF, 4'hF, 4'hF, 4'hF};
    write_burst(4'h5, BASE, 8'd3, 3'd2, 2'b01, 4, 1'b0, dq, sq);
    read_burst(4'h9, BASE, 8'd3, 3'd2, 2'b01, 1'b0);

    dq = {32'hFFFF_FFFF}; sq = {4'hF};
    write_burst(4'h1, BASE + 32'h10, 8'd0, 3'd2, 2'b01, 1, 1'b0, dq, sq);
    dq = {32'hAABB_CCDD}; sq = {4'b0101};
    write_burst(4'h2, BASE + 32'h10, 8'd0, 3'd2, 2'b01, 1, 1'b0, dq, sq);
    read_burst(4'h3, BASE + 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    read_burst(4'h4, BASE + 32'h08, 8'd3, 3'd2, 2'b10, 1'b0);

    read_burst(4'h6, 32'h0000_0000, 8'd1, 3'd2, 2'b01, 1'b0);
    dq = {32'hDEAD_BEEF}; sq = {4'hF};
    write_burst(4'h7, 32'h0000_0000, 8'd0, 3'd2, 2'b01, 1, 1'b0, dq, sq);
    read_burst(4'h8, BASE - 32'd4, 8'd1, 3'd2, 2'b01, 1'b0);
    read_burst(4'hA, TOP, 8'd0, 3'd2, 2'b01, 1'b0);
    fill_random(3, 1'b0);
    write_burst(4'hB, BASE + 32'h20, 8'd3, 3'd2, 2'b01, 3, 1'b0, dq, sq);
    fill_random(5, 1'b1);
    write_burst(4'hC, BASE + 32'h60, 8'd3, 3'd2, 2'b01, 5, 1'b0, dq, sq);
    read_burst(4'hD, BASE + 32'h20, 8'd15, 3'd2, 2'b01, 1'b1);

    for (int t = 0; t < 24; t++) begin
      logic [1:0]  bt;
      logic [2:0]  sz;
      logic [7:0]  ln;
      logic [31:0] ad;
      bt = 2'($urandom_range(0, 3));
      sz = 3'($urandom_range(0, 2));
      ln = (bt == 2'b10) ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 15));
      ad = BASE + 32'($urandom_range(0, 47) * 4) + ((32'($urandom_range(0, 3)) >> sz) << sz);
      if (t % 2 == 1) begin
        fill_random(int'(ln) + 1, 1'b1);
        write_burst(4'($urandom), ad, ln, sz, bt, int'(ln) + 1, 1'b1, dq, sq);
      end else begin
        read_burst(4'($urandom), ad, ln, sz, bt, 1'b1);
      end
    end

    // Write lands on a word the long read is still walking through.
    fill_random(1, 1'b0);
    fork
      read_burst(4'hE, BASE + 32'h40, 8'd15, 3'd2, 2'b01, 1'b0);
      begin
        repeat (4) @(negedge clock);
        write_burst(4'hF, BASE + 32'h58, 8'd0, 3'd2, 2'b01, 1, 1'b0, dq, sq);
      end
    join
    read_burst(4'h1, BASE + 32'h40, 8'd15, 3'd2, 2'b01, 1'b0);

    io_axi_ar_valid = 1'b1; io_axi_ar_bits_id = 4'h3; io_axi_ar_bits_addr = BASE;
    io_axi_ar_bits_len = 8'd15; io_axi_ar_bits_size = 3'd2; io_axi_ar_bits_burst = 2'b01;
    @(negedge clock);
    io_axi_ar_valid = 1'b0;
    io_axi_r_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("reset_mid_r_valid", 32'(io_axi_r_valid), 32'd0);
    check_eq("reset_mid_ar_ready", 32'(io_axi_ar_ready), 32'd1);
    reset = 1'b0;
    io_axi_r_ready = 1'b0;
    @(negedge clock);
    check_eq("reset_no_resume", 32'(io_axi_r_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
